core_mem_arbiter: RTL and testbench
===================================

// Module: core_mem_arbiter
// PURPOSE
//  Shares one external memory port between NUM_CORES pipelined cores in the hybrid multi-core top.
//  Each core raises core_request with its memory_addr, memory_rden, memory_wren and memory_write_val.
//  It stalls until its core_enable bit pulses.
//  The arbiter serialises the transactions with round-robin priority.
//  It drives the shared memory port and returns read data to the granted core.
// PARAMETERS
//  NUM_CORES    4  number of requesting cores, 2..8
//  ADDR_W      32  memory address width
//  DATA_W      32  memory data width
//  MEM_LATENCY  2  cycles from the issue-cycle edge until mem_read_val is valid, 1..15
// PORTS
//  clk              in   1                   single clock, rising edge
//  reset            in   1                   asynchronous, active-low reset
//  core_request     in   NUM_CORES           per-core request, level
//  core_addr        in   NUM_CORES*ADDR_W    per-core address, core i at [i*ADDR_W +: ADDR_W]
//  core_rden        in   NUM_CORES           per-core read strobe
//  core_wren        in   NUM_CORES           per-core write strobe
//  core_write_val   in   NUM_CORES*DATA_W    per-core write data
//  core_enable      out  NUM_CORES           one-hot completion pulse, 1 cycle
//  core_read_val    out  DATA_W              read data; valid in the cycle core_enable is high
//  mem_addr         out  ADDR_W              shared memory address
//  mem_rden         out  1                   shared read strobe
//  mem_wren         out  1                   shared write strobe
//  mem_write_val    out  DATA_W              shared write data
//  mem_read_val     in   DATA_W              shared read data
//  busy             out  1                   high whenever state != IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE and rr_ptr=0. All outputs are 0, including mem strobes and core_enable.
//  - A reset during ISSUE or WAIT aborts the transaction at once. No core_enable is produced for it.
//  - FSM states and transitions:
//    - IDLE: if any core_request bit is high, pick a winner via round-robin from rr_ptr. Latch the winner's addr/rden/wren/wdata, then go to ISSUE.
//    - ISSUE (1 cycle): drive the latched values onto the mem_* outputs. mem_rden/mem_wren are high for this cycle only. Load wait_cnt=MEM_LATENCY, then go to WAIT.
//    - WAIT: decrement wait_cnt each cycle. When wait_cnt==1, register mem_read_val into the read_data reg, then go to RESP.
//    - RESP (1 cycle): core_enable[winner]=1 and core_read_val=read_data. Set rr_ptr=(winner+1) mod NUM_CORES.
//      - If any request is pending, arbitrate and go directly to ISSUE (back-to-back; same rule as IDLE).
//      - Otherwise go to IDLE.
//  - In RESP the just-served core's request bit is masked out of the arbitration.
//    This prevents double service if the core has not yet dropped its request.
//  - Latency: request first high in cycle c0 -> ISSUE c1 -> core_enable at c0+2+MEM_LATENCY.
//  - Sustained throughput: one transaction every MEM_LATENCY+2 cycles.
//  - Round-robin rule: search indices rr_ptr, rr_ptr+1, ... with wrap-around. The first set bit wins.
//    Starvation bound: NUM_CORES-1 transactions.
//  - Inputs are sampled only at arbitration. Changes after the grant are ignored until the next grant.
//  - A request withdrawn mid-transaction still completes, and the core_enable pulse is still issued.
//  - rden=1 and wren=1 together: treated as a write, with mem_rden=0.
//  - rden=0 and wren=0 with a request: no memory strobe, but full latency. core_enable still pulses and core_read_val=0.
//  - Write transactions: core_read_val=0 in RESP.
//  - Outside RESP, core_read_val holds its last value. core_enable is 0.
//  - Outside ISSUE: mem_rden=mem_wren=0. mem_addr and mem_write_val hold their last values.
//  - All outputs are registered or decoded from registered state only. No combinational input-to-output path.
// STRUCTURE
//  - Package core_arb_pkg holds:
//    - state encoding localparams: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
//    - a one-hot-to-index function and the MAX_CORES=8 constant.
//  - Sub-module rr_picker: purely combinational.
//    - Inputs: req[NUM_CORES], ptr, mask_idx, mask_en.
//    - Outputs: grant_valid, grant_idx (clog2 width).
//    - The FSM, counters and datapath latches live in core_mem_arbiter.
// TESTING
//  1. Single read: core 2 requests addr 0x40; memory model returns 0xDEADBEEF after 2 cycles.
//     -> mem_rden pulses 1 cycle with mem_addr=0x40.
//     -> core_enable=4'b0100 at c0+4 with core_read_val=0xDEADBEEF.
//  2. Contention: all 4 cores request continuously from reset.
//     -> grants go in order 0,1,2,3,0 with a spacing of 4 cycles.
//     -> no cycle has more than one core_enable bit set.
//  3. Write: core 1 writes 0x12345678 to 0x10.
//     -> mem_wren=1 and mem_write_val=0x12345678 for exactly 1 cycle, mem_rden=0.
//     -> core_enable[1] pulses and core_read_val=0.
//  4. Sticky requester: core 0 holds its request after core_enable while core 3 is requesting.
//     -> next grant goes to core 3, not core 0.
//  5. Reset mid-WAIT: assert reset one cycle after ISSUE.
//     -> all outputs are 0 immediately (asynchronous).
//     -> no core_enable for that transaction.
//     -> after release with core 3 requesting, core 3 is served with rr_ptr back to 0.
//  6. MEM_LATENCY=1 build: back-to-back requests from cores 0 and 1.
//     -> core_enable pulses exactly 3 cycles apart.

Source files
------------

// File: rtl/core_arb_pkg.sv
// Shared types and helpers for the core memory arbiter.
package core_arb_pkg;

  localparam int unsigned MAX_CORES = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_CORES-1:0] onehot);
    onehot_to_idx = '0;
    for (int unsigned i = 0; i < MAX_CORES; i++) begin
      if (onehot[i]) onehot_to_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
module rr_picker
  import core_arb_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  input  logic [IDX_W-1:0]     mask_idx,
  input  logic                 mask_en,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [NUM_CORES-1:0] req_m;
  logic [IDX_W-1:0]     cand;
  int unsigned          pos;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    pos         = 0;
    req_m       = req;
    if (mask_en) req_m[mask_idx] = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= NUM_CORES) pos = pos - NUM_CORES;
      cand = IDX_W'(pos);
      if (!grant_valid && req_m[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Serialises per-core memory transactions onto one shared memory port, round-robin.
module core_mem_arbiter
  import core_arb_pkg::*;
#(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_request,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES-1:0]        core_rden,
  input  logic [NUM_CORES-1:0]        core_wren,
  input  logic [NUM_CORES*DATA_W-1:0] core_write_val,
  output logic [NUM_CORES-1:0]        core_enable,
  output logic [DATA_W-1:0]           core_read_val,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_rden,
  output logic                        mem_wren,
  output logic [DATA_W-1:0]           mem_write_val,
  input  logic [DATA_W-1:0]           mem_read_val,
  output logic                        busy
);

  localparam int unsigned IDX_W = $clog2(NUM_CORES);

  arb_state_t           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     next_ptr;
  logic [IDX_W-1:0]     pick_ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic [3:0]           wait_cnt;
  logic                 rd_op;
  logic                 sel_rd;
  logic                 sel_wr;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [NUM_CORES-1:0] winner_onehot;

  // In RESP, arbitrate from the pointer the pending update will produce, so a
  // back-to-back grant already honours the new priority order.
  always_comb begin
    next_ptr = (winner == IDX_W'(NUM_CORES - 1)) ? '0 : winner + 1'b1;
    pick_ptr = (state == RESP) ? next_ptr : rr_ptr;
  end

  rr_picker #(
    .NUM_CORES(NUM_CORES),
    .IDX_W    (IDX_W)
  ) u_rr_picker (
    .req        (core_request),
    .ptr        (pick_ptr),
    .mask_idx   (winner),
    .mask_en    (state == RESP),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    sel_addr  = core_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
    sel_wdata = core_write_val[32'(grant_idx)*DATA_W +: DATA_W];
    sel_wr    = core_wren[grant_idx];
    sel_rd    = core_rden[grant_idx] & ~sel_wr;
    winner_onehot         = '0;
    winner_onehot[winner] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      winner        <= '0;
      wait_cnt      <= '0;
      rd_op         <= 1'b0;
      mem_addr      <= '0;
      mem_write_val <= '0;
      mem_rden      <= 1'b0;
      mem_wren      <= 1'b0;
      core_enable   <= '0;
      core_read_val <= '0;
    end else begin
      mem_rden    <= 1'b0;
      mem_wren    <= 1'b0;
      core_enable <= '0;
      case (state)
        IDLE, RESP: begin
          if (state == RESP) rr_ptr <= next_ptr;
          if (grant_valid) begin
            winner        <= grant_idx;
            mem_addr      <= sel_addr;
            mem_write_val <= sel_wdata;
            mem_rden      <= sel_rd;
            mem_wren      <= sel_wr;
            rd_op         <= sel_rd;
            state         <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          wait_cnt <= 4'(MEM_LATENCY);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd1) begin
            core_enable   <= winner_onehot;
            core_read_val <= rd_op ? mem_read_val : '0;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Two arbiters (latency 2 and 1) share one randomized stimulus; each is checked against a transaction-level model.
module tb_core_mem_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    core_request, core_rden, core_wren;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_write_val;

  logic [N-1:0]  core_enable   [2];
  logic [DW-1:0] core_read_val [2];
  logic [AW-1:0] mem_addr      [2];
  logic          mem_rden      [2];
  logic          mem_wren      [2];
  logic [DW-1:0] mem_write_val [2];
  logic [DW-1:0] mem_read_val  [2];
  logic          busy          [2];

  core_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(2)) u_dut_lat2 (
    .clk(clk), .reset(reset), .core_request(core_request), .core_addr(core_addr),
    .core_rden(core_rden), .core_wren(core_wren), .core_write_val(core_write_val),
    .core_enable(core_enable[0]), .core_read_val(core_read_val[0]), .mem_addr(mem_addr[0]),
    .mem_rden(mem_rden[0]), .mem_wren(mem_wren[0]), .mem_write_val(mem_write_val[0]),
    .mem_read_val(mem_read_val[0]), .busy(busy[0]));

  core_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u_dut_lat1 (
    .clk(clk), .reset(reset), .core_request(core_request), .core_addr(core_addr),
    .core_rden(core_rden), .core_wren(core_wren), .core_write_val(core_write_val),
    .core_enable(core_enable[1]), .core_read_val(core_read_val[1]), .mem_addr(mem_addr[1]),
    .mem_rden(mem_rden[1]), .mem_wren(mem_wren[1]), .mem_write_val(mem_write_val[1]),
    .mem_read_val(mem_read_val[1]), .busy(busy[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] dflt(input int unsigned i);
    return (i == 16) ? 32'hDEADBEEF : ((32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction

  // External memory per instance (driven by the DUT strobes) and the reference memory.
  logic [31:0] mem    [2][64];
  logic [31:0] refmem [2][64];
  logic        pipe_v [2][16];
  logic [31:0] pipe_d [2][16];

  // Transaction-level reference: one grant at edge g, strobe at g, response cycle g+L+1.
  int          ecount [2];
  int          g      [2];
  int          w      [2];
  int          ptr    [2];
  bit          active [2];
  bit          t_rd   [2];
  bit          t_wr   [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wval [2];
  logic [31:0] t_rval [2];

  logic          exp_busy [2];
  logic          exp_rden [2];
  logic          exp_wren [2];
  logic [31:0]   exp_addr [2];
  logic [31:0]   exp_wval [2];
  logic [N-1:0]  exp_en   [2];
  logic [31:0]   exp_rv   [2];

  int lat, e, justw, cand;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      lat = lat_of(k);
      if (!reset) begin
        active[k] = 0; ecount[k] = 0; ptr[k] = 0; g[k] = 0; w[k] = 0;
        t_rd[k] = 0; t_wr[k] = 0; t_addr[k] = '0; t_wval[k] = '0; t_rval[k] = '0;
        exp_busy[k] = 0; exp_rden[k] = 0; exp_wren[k] = 0;
        exp_addr[k] = '0; exp_wval[k] = '0; exp_en[k] = '0; exp_rv[k] = '0;
        for (int j = 0; j < 64; j++) begin
          mem[k][j] = dflt(j);
          refmem[k][j] = dflt(j);
        end
        for (int j = 0; j < 16; j++) pipe_v[k][j] = 1'b0;
        mem_read_val[k] <= '0;
      end else begin
        for (int j = 15; j > 0; j--) begin
          pipe_v[k][j] = pipe_v[k][j-1];
          pipe_d[k][j] = pipe_d[k][j-1];
        end
        pipe_v[k][0] = mem_rden[k];
        pipe_d[k][0] = mem[k][mem_addr[k][7:2]];
        if (mem_wren[k]) mem[k][mem_addr[k][7:2]] = mem_write_val[k];
        mem_read_val[k] <= pipe_v[k][lat-1] ? pipe_d[k][lat-1] : $urandom;

        e = ecount[k];
        ecount[k]++;
        justw = -1;
        if (active[k] && e == g[k] + 1) begin
          if (t_wr[k]) refmem[k][t_addr[k][7:2]] = t_wval[k];
          t_rval[k] = t_rd[k] ? refmem[k][t_addr[k][7:2]] : '0;
        end
        if (active[k] && e == g[k] + lat + 2) begin
          active[k] = 0;
          justw = w[k];
          ptr[k] = (w[k] + 1) % N;
        end
        if (!active[k]) begin
          for (int i = 0; i < N; i++) begin
            cand = (ptr[k] + i) % N;
            if (!active[k] && core_request[cand] && cand != justw) begin
              active[k] = 1;
              g[k] = e;
              w[k] = cand;
              t_wr[k] = core_wren[cand];
              t_rd[k] = core_rden[cand] && !core_wren[cand];
              t_addr[k] = core_addr[cand*AW +: AW];
              t_wval[k] = core_write_val[cand*DW +: DW];
              exp_addr[k] = t_addr[k];
              exp_wval[k] = t_wval[k];
            end
          end
        end
        exp_busy[k] = active[k];
        exp_rden[k] = active[k] && e == g[k] && t_rd[k];
        exp_wren[k] = active[k] && e == g[k] && t_wr[k];
        exp_en[k]   = '0;
        if (active[k] && e == g[k] + lat + 1) begin
          exp_en[k] = N'(1) << w[k];
          exp_rv[k] = t_rval[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        check($sformatf("L%0d.rst_en", lat_of(k)), 32'(core_enable[k]), '0);
        check($sformatf("L%0d.rst_busy", lat_of(k)), 32'(busy[k]), '0);
        check($sformatf("L%0d.rst_rden", lat_of(k)), 32'(mem_rden[k]), '0);
        check($sformatf("L%0d.rst_wren", lat_of(k)), 32'(mem_wren[k]), '0);
        check($sformatf("L%0d.rst_addr", lat_of(k)), mem_addr[k], '0);
        check($sformatf("L%0d.rst_rv", lat_of(k)), core_read_val[k], '0);
      end else begin
        check($sformatf("L%0d.busy", lat_of(k)), 32'(busy[k]), 32'(exp_busy[k]));
        check($sformatf("L%0d.rden", lat_of(k)), 32'(mem_rden[k]), 32'(exp_rden[k]));
        check($sformatf("L%0d.wren", lat_of(k)), 32'(mem_wren[k]), 32'(exp_wren[k]));
        check($sformatf("L%0d.addr", lat_of(k)), mem_addr[k], exp_addr[k]);
        check($sformatf("L%0d.wval", lat_of(k)), mem_write_val[k], exp_wval[k]);
        check($sformatf("L%0d.enable", lat_of(k)), 32'(core_enable[k]), 32'(exp_en[k]));
        check($sformatf("L%0d.read_val", lat_of(k)), core_read_val[k], exp_rv[k]);
        check($sformatf("L%0d.onehot", lat_of(k)), 32'($countones(core_enable[k]) <= 1), 32'd1);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_core(input int c, input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] v);
    core_addr[c*AW +: AW]      = a;
    core_rden[c]               = rd;
    core_wren[c]               = wr;
    core_write_val[c*DW +: DW] = v;
  endtask

  task automatic pulse(input logic [N-1:0] r);
    core_request = r;
    wait_cyc(1);
    core_request = '0;
  endtask

  initial begin
    reset = 1'b0;
    core_request = '0; core_rden = '0; core_wren = '0;
    core_addr = '0; core_write_val = '0;
    wait_cyc(3);
    reset = 1'b1;

    set_core(2, 32'h40, 1'b1, 1'b0, 32'h0);
    pulse(4'b0100);
    wait_cyc(8);

    for (int c = 0; c < N; c++) set_core(c, 32'h80 + 32'(c) * 4, 1'b1, 1'b0, 32'h0);
    core_request = 4'hF;
    wait_cyc(22);
    core_request = '0;
    wait_cyc(8);

    set_core(1, 32'h10, 1'b0, 1'b1, 32'h12345678);
    pulse(4'b0010);
    wait_cyc(8);
    set_core(1, 32'h10, 1'b1, 1'b0, 32'h0);
    pulse(4'b0010);
    wait_cyc(8);

    set_core(0, 32'h50, 1'b1, 1'b0, 32'h0);
    set_core(3, 32'h5C, 1'b1, 1'b0, 32'h0);
    core_request = 4'b1001;
    wait_cyc(14);
    core_request = '0;
    wait_cyc(8);

    set_core(0, 32'h20, 1'b1, 1'b1, 32'hCAFEF00D);
    pulse(4'b0001);
    wait_cyc(6);
    set_core(1, 32'h24, 1'b0, 1'b0, 32'hFFFFFFFF);
    pulse(4'b0010);
    wait_cyc(6);
    set_core(2, 32'h20, 1'b1, 1'b0, 32'h0);
    pulse(4'b0100);
    wait_cyc(8);

    set_core(0, 32'h60, 1'b1, 1'b0, 32'h0);
    pulse(4'b0001);
    wait_cyc(1);
    reset = 1'b0;
    set_core(3, 32'h64, 1'b1, 1'b0, 32'h0);
    core_request = 4'b1000;
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(6);
    core_request = '0;
    wait_cyc(6);

    set_core(0, 32'h70, 1'b1, 1'b0, 32'h0);
    set_core(1, 32'h74, 1'b1, 1'b0, 32'h0);
    core_request = 4'b0011;
    wait_cyc(12);
    core_request = '0;
    wait_cyc(6);

    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if (core_request[c]) core_request[c] = ($urandom_range(0, 5) != 0);
        else                 core_request[c] = ($urandom_range(0, 2) == 0);
        set_core(c, {24'h0, 6'($urandom), 2'b00}, 1'($urandom), ($urandom_range(0, 3) == 0),
                 $urandom);
      end
      if ($urandom_range(0, 79) == 0) begin
        #2 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
      end else begin
        wait_cyc(1);
      end
    end
    core_request = '0;
    wait_cyc(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
